// File: rtl/sr_ff_response_checker.sv
// Passive response checker for an SR flip-flop: tracks a golden model from the
// flip-flop's own stimulus and scores its q/qb outputs every clock.
module sr_ff_response_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             dut_rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qb,
  output logic             model_q,
  output logic             model_known,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] check_cnt,
  output logic             first_err,
  output logic [1:0]       first_err_code
);

  typedef enum logic {
    UNKNOWN = 1'b0,
    KNOWN   = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   model_q_nxt;
  logic   do_cmp;
  logic   q_bad;
  logic   qb_bad;
  logic   mismatch;
  logic   illegal;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Model next state; dut_rst outranks every s/r combination, including s=r=1.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_nxt   = state;
    model_q_nxt = model_q;
    if (dut_rst) begin
      state_nxt   = KNOWN;
      model_q_nxt = 1'b0;
    end else begin
      unique case ({s, r})
        2'b10:   begin state_nxt = KNOWN; model_q_nxt = 1'b1; end
        2'b01:   begin state_nxt = KNOWN; model_q_nxt = 1'b0; end
        2'b11:   state_nxt = UNKNOWN;
        default: ;
      endcase
    end
  end

  assign model_known = (state == KNOWN);

  // Case inequality so that an undriven or X output scores as wrong.
  assign do_cmp   = chk_en & model_known;
  assign q_bad    = (q !== model_q);
  assign qb_bad   = (qb !== ~q);
  assign mismatch = do_cmp & (q_bad | qb_bad);
  assign illegal  = chk_en & ~dut_rst & s & r;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments for all registered state.
      state          <= UNKNOWN;
      model_q        <= 1'b0;
      err_pulse      <= 1'b0;
      err_cnt        <= '0;
      illegal_cnt    <= '0;
      check_cnt      <= '0;
      first_err      <= 1'b0;
      first_err_code <= 2'b00;
    end else begin
      state     <= state_nxt;
      model_q   <= model_q_nxt;
      err_pulse <= mismatch;
      if (do_cmp)   check_cnt   <= sat_inc(check_cnt);
      if (mismatch) err_cnt     <= sat_inc(err_cnt);
      if (illegal)  illegal_cnt <= sat_inc(illegal_cnt);
      if (mismatch && !first_err) begin
        first_err      <= 1'b1;
        first_err_code <= {qb_bad, q_bad};
      end
    end
  end

endmodule
